// File: rtl/cpu_core_param_if.sv
// Command/operand/result bundle for cpu_core_param.
// The master drives commands and operands; the slave (the core) returns status and result.
interface cpu_core_param_if #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4
);
  localparam int SEL_W = $clog2(NUM_IN);
  localparam int CMD_W = 4 + 2*SEL_W;

  logic                    cmd_valid;
  logic [CMD_W-1:0]        cmd_in;
  logic [NUM_IN*WIDTH-1:0] din;
  logic                    cpu_rdy;
  logic [2*WIDTH-1:0]      out_reg;
  logic                    done;
  logic                    zero;
  logic                    error;

  modport master (
    output cmd_valid, cmd_in, din,
    input  cpu_rdy, out_reg, done, zero, error
  );

  modport slave (
    input  cmd_valid, cmd_in, din,
    output cpu_rdy, out_reg, done, zero, error
  );
endinterface

// File: rtl/cpu_core_param.sv
// Parametrised multi-channel CPU core: ALU, load/store data memory and an optional
// sequential shift-add multiplier enabled by the CPU_MUL_EN macro.
module cpu_core_param #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4,
  parameter int ADDR_W = WIDTH
) (
  input logic            clk,
  input logic            reset,
  cpu_core_param_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_IN);
  localparam int CMD_W = 4 + 2*SEL_W;
  localparam int DW    = 2*WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MEMRD
`ifdef CPU_MUL_EN
    , S_MUL
`endif
  } state_e;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND = 4'd2,  OP_OR   = 4'd3,
    OP_XOR  = 4'd4,  OP_NOT  = 4'd5,  OP_SHL = 4'd6,  OP_SHR  = 4'd7,
    OP_MUL  = 4'd8,  OP_PASS = 4'd9,  OP_LOAD = 4'd10, OP_STORE = 4'd11,
    OP_CMP  = 4'd12
  } op_e;

  state_e             state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               bad_q, bad_d;
  logic [DW-1:0]      out_q, out_d;
  logic               zero_q, zero_d, err_q, err_d, done_q, done_d;
  logic               mem_we;
  logic [DW-1:0]      rd_q;
  logic [DW-1:0]      mem_q [2**ADDR_W];

  logic [3:0]         cmd_op;
  logic [SEL_W-1:0]   cmd_sa, cmd_sb;
  logic [WIDTH-1:0]   din_a, din_b;
  logic               sel_bad;
  logic [DW-1:0]      a_ext, b_ext, res;
  logic               res_wr, res_err;

`ifdef CPU_MUL_EN
  localparam int CNT_W = $clog2(WIDTH);
  logic [DW-1:0]      acc_q, acc_d, mcand_q, mcand_d, mul_sum;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
`endif

  assign cmd_op = bus.cmd_in[CMD_W-1 -: 4];
  assign cmd_sa = bus.cmd_in[2*SEL_W-1 -: SEL_W];
  assign cmd_sb = bus.cmd_in[SEL_W-1:0];
  assign a_ext  = {{WIDTH{1'b0}}, a_q};
  assign b_ext  = {{WIDTH{1'b0}}, b_q};

  always_comb begin
    din_a   = '0;
    din_b   = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (cmd_sa == SEL_W'(k)) din_a = bus.din[k*WIDTH +: WIDTH];
      if (cmd_sb == SEL_W'(k)) din_b = bus.din[k*WIDTH +: WIDTH];
    end
    sel_bad = (int'(cmd_sa) >= NUM_IN) || (int'(cmd_sb) >= NUM_IN);
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    bad_d   = bad_q;
    out_d   = out_q;
    zero_d  = zero_q;
    err_d   = err_q;
    done_d  = 1'b0;
    mem_we  = 1'b0;
    res     = '0;
    res_wr  = 1'b0;
    res_err = 1'b0;
`ifdef CPU_MUL_EN
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    mul_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          op_d    = cmd_op;
          a_d     = din_a;
          b_d     = din_b;
          bad_d   = sel_bad;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        err_d   = 1'b0;
        if (bad_q) begin
          err_d = 1'b1;
        end else begin
          case (op_q)
            OP_ADD:  begin res = a_ext + b_ext;                 res_wr = 1'b1; end
            OP_SUB:  begin res = {{WIDTH{1'b0}}, a_q - b_q};    res_wr = 1'b1; res_err = (a_q < b_q); end
            OP_AND:  begin res = a_ext & b_ext;                 res_wr = 1'b1; end
            OP_OR:   begin res = a_ext | b_ext;                 res_wr = 1'b1; end
            OP_XOR:  begin res = a_ext ^ b_ext;                 res_wr = 1'b1; end
            OP_NOT:  begin res = {{WIDTH{1'b0}}, ~a_q};         res_wr = 1'b1; end
            OP_SHL:  begin res = a_ext << 1;                    res_wr = 1'b1; end
            OP_SHR:  begin res = a_ext >> 1;                    res_wr = 1'b1; end
            OP_PASS: begin res = a_ext;                         res_wr = 1'b1; end
            OP_CMP:  begin res = DW'(a_q == b_q);               res_wr = 1'b1; end
            OP_STORE: mem_we = 1'b1;
            OP_LOAD: begin
              // rd_q samples mem[a_q] at this edge; the result lands one edge later
              done_d  = 1'b0;
              err_d   = err_q;
              state_d = S_MEMRD;
            end
`ifdef CPU_MUL_EN
            OP_MUL: begin
              // iteration 0 happens here, the remaining WIDTH-1 run in S_MUL
              done_d   = 1'b0;
              err_d    = err_q;
              acc_d    = b_q[0] ? a_ext : '0;
              mcand_d  = a_ext << 1;
              mplier_d = b_q >> 1;
              cnt_d    = CNT_W'(1);
              state_d  = S_MUL;
            end
`endif
            default: err_d = 1'b1;
          endcase
          if (res_wr) begin
            out_d  = res;
            zero_d = (res == '0);
            err_d  = res_err;
          end
        end
      end
      S_MEMRD: begin
        out_d   = rd_q;
        zero_d  = (rd_q == '0);
        err_d   = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
`ifdef CPU_MUL_EN
      S_MUL: begin
        acc_d    = mul_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          out_d   = mul_sum;
          zero_d  = (mul_sum == '0);
          err_d   = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      bad_q    <= 1'b0;
      out_q    <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
`ifdef CPU_MUL_EN
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      bad_q    <= bad_d;
      out_q    <= out_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
      done_q   <= done_d;
`ifdef CPU_MUL_EN
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  // Data memory is never reset; a reset on the STORE edge suppresses the write
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem_q[a_q[ADDR_W-1:0]] <= out_q;
    rd_q <= mem_q[a_q[ADDR_W-1:0]];
  end

  assign bus.cpu_rdy = (state_q == S_IDLE);
  assign bus.out_reg = out_q;
  assign bus.done    = done_q;
  assign bus.zero    = zero_q;
  assign bus.error   = err_q;
endmodule

// File: doc/cpu_core_param.md
# cpu_core_param

Parametrised CPU core: NUM_IN operand channels, WIDTH-bit operands, 2*WIDTH-bit result register and data memory. Commands enter through a valid/ready handshake. A control FSM sequences operand capture, ALU execution, an optional multi-cycle multiply, and memory load/store. The core drops in wherever the fixed 4-input, 8-bit CPU top is used today, and the width, channel count and memory depth are set by parameters.

## Interface
- WIDTH, 8, operand width; the result and memory word are 2*WIDTH.
- NUM_IN, 4, number of operand channels (≥2); SEL_W = $clog2(NUM_IN).
- ADDR_W, WIDTH, memory address width; the memory has 2**ADDR_W words.
- CMD_W, 4+2*SEL_W, command width, fixed by the other parameters.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  a command is present on cmd_in.
- cmd_in  in  CMD_W  fields {opcode[3:0], sel_a[SEL_W-1:0], sel_b[SEL_W-1:0]}, opcode in the MSBs.
- din  in  NUM_IN*WIDTH  packed operands; channel k is din[k*WIDTH +: WIDTH].
- cpu_rdy  out  1  high only in IDLE; a command is accepted when cmd_valid && cpu_rdy.
- out_reg  out  2*WIDTH  result register.
- done  out  1  one-cycle pulse when a command completes.
- zero  out  1  set when the last written result is 0.
- error  out  1  error status of the last completed command.

## Operation
- On acceptance, latch opcode, A=din[sel_a] and B=din[sel_b] into internal registers.
- Opcodes:
  - 0 ADD: out_reg = A+B, zero-extended.
  - 1 SUB: out_reg = {0,(A-B) mod 2^WIDTH}; error=1 if A<B.
  - 2 AND, 3 OR, 4 XOR: bitwise on A and B.
  - 5 NOT: ~A.
  - 6 SHL: A<<1, 2*WIDTH wide, so bit WIDTH-1 is kept.
  - 7 SHR: A>>1.
  - 8 MUL: A*B (see Configuration).
  - 9 PASS: A.
  - 10 LOAD: out_reg = mem[A[ADDR_W-1:0]].
  - 11 STORE: mem[A[ADDR_W-1:0]] = out_reg; out_reg and zero unchanged.
  - 12 CMP: out_reg = {0,1} if A==B, else 0.
  - 13–15 illegal: error=1; out_reg and zero unchanged.
- Any sel ≥ NUM_IN is treated like an illegal opcode.
- For every command that writes out_reg, zero = (new out_reg == 0) and error as defined per opcode, otherwise 0.
- STORE completes with error=0.
- FSM states: IDLE → EXEC; EXEC → IDLE (ALU/STORE/illegal), → MEMRD (LOAD), → MUL (MUL).
  - MEMRD → IDLE.
  - MUL → IDLE when the iteration counter reaches WIDTH-1.
- Memory: synchronous read and write, 2*WIDTH wide, not reset.
- cmd_valid while busy is ignored. The source holds the command until cpu_rdy is high.

## Timing
Edge 0 is the accepting edge.
- Reset values: out_reg=0, zero=0, error=0, done=0, cpu_rdy=1, state IDLE, MUL counter 0.
- ALU, STORE and illegal commands:
  - out_reg, zero and error are updated at edge 1; the STORE write also happens at edge 1.
  - done is high for the cycle after edge 1, and cpu_rdy is high in that same cycle.
  - Minimum command spacing is 2 cycles.
- LOAD: read is issued at edge 1, out_reg is written at edge 2, done follows edge 2.
- MUL (macro defined): radix-2 shift-add over WIDTH cycles, with one iteration per edge from edge 1 through edge WIDTH. out_reg is written at edge WIDTH, and done follows edge WIDTH.
- A new command may be accepted in the same cycle done is high.
- Reset asserted mid-operation:
  - The operation is aborted and all outputs take their reset values at that edge.
  - A pending LOAD or MUL result is discarded.
  - A STORE write occurs only if its edge-1 write edge has no reset.

## Configuration
- CPU_MUL_EN defined: opcode 8 performs the sequential multiply described above and the MUL state exists.
- CPU_MUL_EN undefined: opcode 8 behaves as an illegal opcode (error=1 at edge 1, out_reg unchanged). No multiplier logic or counter is synthesised.

## Test plan
All cases use WIDTH=8, NUM_IN=4.
- ADD: din0=200, din1=100, opcode 0, sel_a=0, sel_b=1 → out_reg=0x012C, zero=0, error=0; done is high exactly one cycle after edge 1.
- SUB underflow: din2=5, din3=9, opcode 1 → out_reg=0x00FC, error=1. Then din2=din3=7 → out_reg=0, zero=1, error=0.
- STORE/LOAD:
  - Set out_reg=0x012C. STORE with din2=0x10 → out_reg stays 0x012C, error=0.
  - PASS din0=0 → out_reg=0.
  - LOAD with sel_a=2 → out_reg=0x012C at edge 2, done after edge 2.
- MUL with CPU_MUL_EN: din0=din1=255 → out_reg=0xFE01 at edge 8, cpu_rdy low for 8 cycles. Without CPU_MUL_EN: error=1 at edge 1, out_reg unchanged.
- Illegal opcode 15 → error=1, out_reg unchanged. A second command held on cmd_valid during EXEC is accepted only when cpu_rdy rises and produces exactly one done.
- Reset at edge 3 of a MUL → out_reg=0, error=0, done=0, cpu_rdy=1 in the next cycle; a following ADD 1+1 → out_reg=2.
